// File: rtl/mod_aes_pkg.sv
// Shared definitions for the modified AES-128 round sequencer.
// Holds the block and round-number widths, the controller FSM state
// encoding, default sequencing parameters and a small round-compare helper.
package mod_aes_pkg;

    localparam int BLOCK_W               = 128;
    localparam int RND_W                 = 4;
    localparam int DEFAULT_NUM_ROUNDS    = 10;
    localparam int DEFAULT_ROUND_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when the given round number is the final one of the block.
    function automatic logic is_last(input logic [RND_W-1:0] rnd,
                                     input logic [RND_W-1:0] last_rnd);
        return (rnd == last_rnd);
    endfunction

endpackage

// File: rtl/mod_aes_lat_timer.sv
// Load/decrement latency counter with a registered zero flag.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - load load_val (has priority over dec)
//   dec         - decrement when the count is not already zero
//   load_val    - value loaded on load
//   zero        - registered flag, high when the count is zero
module mod_aes_lat_timer
    import mod_aes_pkg::*;
#(
    parameter int W = RND_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;
    logic         zero_r;

    // Next count: load wins, otherwise saturating decrement towards zero.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_nxt_s = cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register and its zero flag, updated together so the flag
    // always describes the count that is currently held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {W{1'b0}};
            zero_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_nxt_s;
            zero_r <= (cnt_nxt_s == {W{1'b0}});
        end
    end

    assign zero = zero_r;

endmodule

// File: rtl/mod_aes_round_ctrl.sv
// Iterative sequencer for the modified AES-128 round datapath.
// Accepts a plaintext/key pair, applies the initial key whitening, then
// issues NUM_ROUNDS round operations to a shared datapath, holding the
// running state and round key between rounds, and finally presents the
// ciphertext on a valid/ready output.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   in_valid/in_ready           - input handshake, in_data/in_key sampled on accept
//   out_valid/out_ready         - output handshake, out_data is the ciphertext
//   busy                        - high whenever not idle
//   rnd_start                   - one-cycle launch pulse for the datapath
//   rnd_num/rnd_last            - current round number and final-round flag
//   rnd_data/rnd_key            - state and round key fed to the datapath
//   rnd_data_in/rnd_key_in      - datapath results, valid ROUND_LATENCY cycles after rnd_start
module mod_aes_round_ctrl
    import mod_aes_pkg::*;
#(
    parameter int NUM_ROUNDS    = DEFAULT_NUM_ROUNDS,
    parameter int ROUND_LATENCY = DEFAULT_ROUND_LATENCY
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [BLOCK_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy,
    output logic               rnd_start,
    output logic [RND_W-1:0]   rnd_num,
    output logic               rnd_last,
    output logic [BLOCK_W-1:0] rnd_data,
    output logic [BLOCK_W-1:0] rnd_key,
    input  logic [BLOCK_W-1:0] rnd_data_in,
    input  logic [BLOCK_W-1:0] rnd_key_in
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);
    // The WAIT state is left once the counter has reached zero, so it is
    // loaded one short of the datapath latency.
    localparam logic [RND_W-1:0] LAT_LOAD = RND_W'(ROUND_LATENCY - 1);
    localparam logic [RND_W-1:0] RND_ONE  = {{(RND_W-1){1'b0}}, 1'b1};

    state_e               fsm_r;
    logic [BLOCK_W-1:0]   state_r;
    logic [BLOCK_W-1:0]   key_r;
    logic [RND_W-1:0]     round_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [BLOCK_W-1:0]   out_data_r;
    logic                 busy_r;
    logic                 rnd_start_r;
    logic                 rnd_last_r;

    logic                 lat_load_s;
    logic                 lat_dec_s;
    logic                 lat_zero_s;

    // Timer control: load while issuing, count down while waiting.
    always_comb begin
        lat_load_s = 1'b0;
        lat_dec_s  = 1'b0;
        if (fsm_r == ST_ISSUE) begin
            lat_load_s = 1'b1;
        end else if (fsm_r == ST_WAIT) begin
            lat_dec_s = 1'b1;
        end else begin
            lat_load_s = 1'b0;
            lat_dec_s  = 1'b0;
        end
    end

    mod_aes_lat_timer #(
        .W (RND_W)
    ) u_lat_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lat_load_s),
        .dec      (lat_dec_s),
        .load_val (LAT_LOAD),
        .zero     (lat_zero_s)
    );

    // Controller FSM, working registers and registered outputs.
    // Output registers are set on the transition into the state that owns
    // them, so every output is a flop and reflects the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= ST_IDLE;
            state_r     <= {BLOCK_W{1'b0}};
            key_r       <= {BLOCK_W{1'b0}};
            round_r     <= {RND_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= {BLOCK_W{1'b0}};
            busy_r      <= 1'b0;
            rnd_start_r <= 1'b0;
            rnd_last_r  <= 1'b0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        state_r     <= in_data ^ in_key;
                        key_r       <= in_key;
                        round_r     <= RND_ONE;
                        fsm_r       <= ST_ISSUE;
                        in_ready_r  <= 1'b0;
                        busy_r      <= 1'b1;
                        rnd_start_r <= 1'b1;
                        rnd_last_r  <= is_last(RND_ONE, LAST_RND);
                    end
                end
                ST_ISSUE: begin
                    fsm_r       <= ST_WAIT;
                    rnd_start_r <= 1'b0;
                end
                ST_WAIT: begin
                    if (lat_zero_s) begin
                        state_r <= rnd_data_in;
                        key_r   <= rnd_key_in;
                        if (rnd_last_r) begin
                            fsm_r       <= ST_DONE;
                            out_valid_r <= 1'b1;
                            out_data_r  <= rnd_data_in;
                        end else begin
                            round_r     <= round_r + RND_ONE;
                            fsm_r       <= ST_ISSUE;
                            rnd_start_r <= 1'b1;
                            rnd_last_r  <= is_last(round_r + RND_ONE, LAST_RND);
                        end
                    end
                end
                ST_DONE: begin
                    // Returning to idle also clears the round indicators so
                    // the datapath sees no stale round between blocks.
                    if (out_ready) begin
                        fsm_r       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        out_data_r  <= {BLOCK_W{1'b0}};
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        round_r     <= {RND_W{1'b0}};
                        rnd_last_r  <= 1'b0;
                    end
                end
                default: begin
                    fsm_r       <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_data_r  <= {BLOCK_W{1'b0}};
                    busy_r      <= 1'b0;
                    rnd_start_r <= 1'b0;
                    rnd_last_r  <= 1'b0;
                    round_r     <= {RND_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign rnd_start = rnd_start_r;
    assign rnd_num   = round_r;
    assign rnd_last  = rnd_last_r;
    assign rnd_data  = state_r;
    assign rnd_key   = key_r;

endmodule

// File: tb/tb_mod_aes_round_ctrl.sv
// Scoreboard bench for mod_aes_round_ctrl: a default instance driven with
// directed and random blocks, plus a NUM_ROUNDS=1/ROUND_LATENCY=1 instance.
// Datapath stub: returns rnd_data+1 and rnd_key unchanged after the latency,
// so the expected ciphertext is (data ^ key) + NUM_ROUNDS.
module tb_mod_aes_round_ctrl;

    localparam int NR      = 10;
    localparam int RL      = 2;
    localparam int NR1     = 1;
    localparam int RL1     = 1;
    localparam int EXP_LAT = 1 + NR * (1 + RL);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance signals
    logic         in_valid, in_ready, out_valid, out_ready, busy, rnd_start, rnd_last;
    logic [127:0] in_data, in_key, out_data, rnd_data, rnd_key, rnd_data_in, rnd_key_in;
    logic [3:0]   rnd_num;
    // short instance signals
    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1, rnd_start1, rnd_last1;
    logic [127:0] in_data1, in_key1, out_data1, rnd_data1, rnd_key1, rnd_data_in1, rnd_key_in1;
    logic [3:0]   rnd_num1;

    mod_aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .rnd_start(rnd_start), .rnd_num(rnd_num),
        .rnd_last(rnd_last), .rnd_data(rnd_data), .rnd_key(rnd_key),
        .rnd_data_in(rnd_data_in), .rnd_key_in(rnd_key_in));

    mod_aes_round_ctrl #(.NUM_ROUNDS(NR1), .ROUND_LATENCY(RL1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_key(in_key1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .busy(busy1), .rnd_start(rnd_start1), .rnd_num(rnd_num1),
        .rnd_last(rnd_last1), .rnd_data(rnd_data1), .rnd_key(rnd_key1),
        .rnd_data_in(rnd_data_in1), .rnd_key_in(rnd_key_in1));

    // Datapath stubs: capture on rnd_start, present result once RL cycles
    // have elapsed, and present inverted (wrong) values before that.
    logic [127:0] cap0, capk0, cap1, capk1;
    int sc0, sc1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap0 <= '0; capk0 <= '0; sc0 <= 0;
        end else if (rnd_start) begin
            cap0 <= rnd_data; capk0 <= rnd_key; sc0 <= 1;
        end else if (sc0 != 0 && sc0 < RL) begin
            sc0 <= sc0 + 1;
        end
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap1 <= '0; capk1 <= '0; sc1 <= 0;
        end else if (rnd_start1) begin
            cap1 <= rnd_data1; capk1 <= rnd_key1; sc1 <= 1;
        end else if (sc1 != 0 && sc1 < RL1) begin
            sc1 <= sc1 + 1;
        end
    end
    assign rnd_data_in  = (sc0 == RL)  ? cap0 + 128'd1 : ~(cap0 + 128'd1);
    assign rnd_key_in   = (sc0 == RL)  ? capk0 : ~capk0;
    assign rnd_data_in1 = (sc1 == RL1) ? cap1 + 128'd1 : ~(cap1 + 128'd1);
    assign rnd_key_in1  = (sc1 == RL1) ? capk1 : ~capk1;

    typedef struct {
        logic [127:0] d;
        logic [127:0] k;
        logic [127:0] exp_out;
        int           t_acc;
    } blk_t;
    blk_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer one block once the controller is idle; record the expectation.
    task automatic send(input logic [127:0] d, input logic [127:0] k);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("send_ready", {127'd0, in_ready}, 128'd1);
        if (in_ready) begin
            in_data  = d;
            in_key   = k;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            sb_q.push_back('{d, k, (d ^ k) + 128'(NR), cyc});
            in_valid = 1'b0;
            in_data  = rnd128();
            in_key   = rnd128();
        end
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("drain", 128'(sb_q.size()), 128'd0);
    endtask

    // Monitor / scoreboard for the default instance.
    int           pulses  = 0;
    logic         prev_ov = 1'b0;
    logic         chk_idle = 1'b0;
    logic [127:0] hold;
    always @(negedge clk) begin
        if (!rst_n) begin
            pulses   = 0;
            prev_ov  = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                check("idle_after_hs", {125'd0, out_valid, in_ready, busy}, 128'b010);
                chk_idle = 1'b0;
            end
            if (rnd_start) begin
                pulses++;
                check("rnd_num", 128'(rnd_num), 128'(pulses));
                check("rnd_last", {127'd0, rnd_last}, {127'd0, (pulses == NR)});
                if (pulses == 1 && sb_q.size() != 0) begin
                    check("r1_data", rnd_data, sb_q[0].d ^ sb_q[0].k);
                    check("r1_key", rnd_key, sb_q[0].k);
                end
            end
            if (out_valid) begin
                if (!prev_ov) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out", 128'd1, 128'd0);
                    end else begin
                        check("out_data", out_data, sb_q[0].exp_out);
                        check("latency", 128'(cyc - sb_q[0].t_acc + 1), 128'(EXP_LAT));
                        check("pulse_count", 128'(pulses), 128'(NR));
                    end
                    hold = out_data;
                end else begin
                    check("hold_data", out_data, hold);
                    check("hold_ctrl", {125'd0, in_ready, rnd_start, busy}, 128'b001);
                end
                if (out_ready) begin
                    if (sb_q.size() != 0) void'(sb_q.pop_front());
                    pulses   = 0;
                    chk_idle = 1'b1;
                end
            end
            prev_ov = out_valid && !out_ready;
        end
    end

    logic stim_done = 1'b0;

    initial begin
        int w;
        int t1;
        in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; in_key1 = '0; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {out_valid, in_ready, busy, rnd_start, rnd_last, rnd_num}, {119'd0, 9'b0_1_0_0_0_0000});
        check("rst_out_data", out_data, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", {out_valid, in_ready, busy, rnd_start, rnd_last, rnd_num}, {119'd0, 9'b0_1_0_0_0_0000});
        check("idle_out_data", out_data, 128'd0);
        check("idle_ready1", {127'd0, in_ready1}, 128'd1);

        // directed blocks, downstream always ready
        @(posedge clk); #1 out_ready = 1'b1;
        send(128'h0, 128'h0);
        send(128'h5, 128'h3);
        wait_drain();

        // backpressure: hold out_ready low for 20 cycles after out_valid
        @(posedge clk); #1 out_ready = 1'b0;
        send(rnd128(), rnd128());
        w = 0;
        while (!out_valid && w < 200) begin @(negedge clk); w++; end
        check("bp_valid", {127'd0, out_valid}, 128'd1);
        repeat (20) @(negedge clk);
        check("bp_still_valid", {127'd0, out_valid}, 128'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();

        // reset during round 5
        send(rnd128(), rnd128());
        w = 0;
        while (rnd_num != 4'd5 && w < 200) begin @(negedge clk); w++; end
        check("reach_r5", 128'(rnd_num), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {out_valid, in_ready, busy, rnd_start, rnd_last, rnd_num}, {119'd0, 9'b0_1_0_0_0_0000});
        check("mid_rst_dp", {out_data ^ rnd_data ^ rnd_key}, 128'd0);
        sb_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(128'h1234, 128'hFFFF_0000);
        wait_drain();

        // random blocks with random downstream stalls
        fork
            begin
                for (int i = 0; i < 8; i++) send(rnd128(), rnd128());
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();

        // single round, single-cycle latency instance
        @(negedge clk);
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        t1 = cyc;
        in_valid1 = 1'b0;
        w = 0;
        @(negedge clk);
        while (!out_valid1 && w < 50) begin
            if (rnd_start1) begin
                check("s_rnd_last", {123'd0, rnd_last1, rnd_num1}, {123'd0, 1'b1, 4'd1});
            end
            @(negedge clk);
            w++;
        end
        check("s_latency", 128'(cyc - t1 + 1), 128'd3);
        check("s_out_data", out_data1, 128'h1);
        @(negedge clk);
        check("s_idle", {126'd0, out_valid1, in_ready1}, 128'b01);

        check("sb_empty", 128'(sb_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mod_aes_round_ctrl.md
Name: mod_aes_round_ctrl

Overview:
Iterative sequencer for the modified AES-128 round datapath. Accepts one plaintext/key pair per transaction over a valid/ready handshake and performs the initial key whitening. It then issues NUM_ROUNDS round operations to a single shared round datapath instance, marking the final one with rnd_last. Between rounds it holds the running state and round key in its own registers, and presents the ciphertext over a valid/ready output handshake. It sits between the top-level I/O and the round/key-expansion datapath.

Parameters:
NUM_ROUNDS, 10, rounds issued per block; legal range 1..15 (rnd_num is 4 bits)
ROUND_LATENCY, 2, clk cycles from rnd_start until rnd_data_in/rnd_key_in are valid; legal range 1..15

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input block offered
in_ready  out  1  controller can accept a block
in_data  in  128  plaintext
in_key  in  128  cipher key
out_valid  out  1  ciphertext available
out_ready  in  1  downstream accepts ciphertext
out_data  out  128  ciphertext
busy  out  1  high in every state except IDLE
rnd_start  out  1  one-cycle pulse launching a round on the datapath
rnd_num  out  4  current round number, 1..NUM_ROUNDS
rnd_last  out  1  high when rnd_num == NUM_ROUNDS (datapath selects last-round form)
rnd_data  out  128  state fed to the datapath (state_reg)
rnd_key  out  128  key fed to the datapath (key_reg)
rnd_data_in  in  128  round result from the datapath
rnd_key_in  in  128  next round key from the datapath

Behaviour:
- Reset (asynchronous, rst_n=0): FSM=IDLE, state_reg=0, key_reg=0, round=0, wait_cnt=0. Resulting outputs: in_ready=1, out_valid=0, out_data=0, busy=0, rnd_start=0, rnd_num=0, rnd_last=0.
- Reset mid-operation aborts the block. No output is produced and the next transaction starts clean.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: state_reg<=in_data^in_key, key_reg<=in_key, round<=1, go to ISSUE.
- ISSUE (one cycle): rnd_start=1, rnd_num=round, rnd_last=(round==NUM_ROUNDS). Load wait_cnt<=ROUND_LATENCY-1, go to WAIT.
- WAIT: rnd_start=0. rnd_num, rnd_last, rnd_data and rnd_key stay stable throughout.
  - If wait_cnt!=0: decrement.
  - If wait_cnt==0: state_reg<=rnd_data_in, key_reg<=rnd_key_in. Then if rnd_last, go to DONE; else round<=round+1 and go to ISSUE.
- DONE: out_valid=1, out_data=state_reg, held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- out_data reads 0 outside DONE.
- in_ready=0 in every state except IDLE. No input is accepted in the cycle the output handshake completes.
- Backpressure: out_ready may be low indefinitely. The FSM stays in DONE with all outputs frozen.
- Latency: the accept edge is cycle 0 and ISSUE for round 1 is cycle 1. Each round takes 1+ROUND_LATENCY cycles. out_valid rises at cycle 1+NUM_ROUNDS*(1+ROUND_LATENCY), which is 31 at the defaults.
- Throughput: one block per 2+NUM_ROUNDS*(1+ROUND_LATENCY) cycles when out_ready is held high.
- NUM_ROUNDS=1: the first ISSUE already has rnd_last=1.
- ROUND_LATENCY=1: WAIT lasts exactly one cycle.
- in_valid while busy is ignored. in_data and in_key are sampled only at the accept edge.

Decomposition:
- Shared package mod_aes_pkg holds: block width constant 128; round-number width 4; the FSM state enum {IDLE, ISSUE, WAIT, DONE}; the default NUM_ROUNDS.
- One sub-module, mod_aes_lat_timer: a load/decrement counter with a zero flag, instantiated for wait_cnt.
- FSM and registers stay in the top module.

Test Plan:
Use a stub datapath that returns rnd_data+1 and rnd_key unchanged after ROUND_LATENCY cycles.
- Reset then idle: check in_ready=1, busy=0, out_valid=0, out_data=0, rnd_num=0.
- in_data=0, in_key=0, defaults -> out_valid at cycle 31; out_data=128'h0A; exactly 10 rnd_start pulses; rnd_last high only for rnd_num=10.
- in_data=128'h5, in_key=128'h3 -> out_data=128'h10; ISSUE of round 1 shows rnd_data=128'h6 and rnd_key=128'h3.
- out_ready held low for 20 cycles after out_valid -> out_data stable, in_ready=0, no rnd_start; out_ready=1 returns to IDLE the next cycle.
- rst_n asserted during round 5 -> every output at its reset value immediately; a following block completes with the correct result.
- NUM_ROUNDS=1, ROUND_LATENCY=1, in_data=in_key=0 -> out_valid at cycle 3, out_data=128'h1.
